// File: rtl/mem_write_buffer_pkg.sv
// Shared definitions for the posted write buffer: FSM states and default geometry.
package mem_write_buffer_pkg;

  localparam int unsigned MEM_ADDR_WIDTH = 32;
  localparam int unsigned MEM_DATA_WIDTH = 64;
  localparam int unsigned WBUF_DEPTH     = 4;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_RD_MEM,
    WB_WR_MEM,
    WB_RESP
  } wb_state_e;

endpackage

// File: rtl/mem_write_buffer_store.sv
// Line-entry storage for the write buffer: circular FIFO with in-place coalescing and
// a parallel address match. The hit_data_o port exists only when WBUF_FWD_EN is defined.
module mem_write_buffer_store
  import mem_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = WBUF_DEPTH,
  parameter int unsigned ADDR_W = MEM_ADDR_WIDTH,
  parameter int unsigned DATA_W = MEM_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              coalesce_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              hit_o,
`ifdef WBUF_FWD_EN
  output logic [DATA_W-1:0] hit_data_o,
`endif
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q, hit_idx;
  logic [PTR_W:0]    count_q, count_d;
  logic              empty_q;

  // Walk entries oldest to youngest so the last match wins (youngest data).
  always_comb begin
    hit_o   = 1'b0;
    hit_idx = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if ((k < 32'(count_q)) && (addr_q[head_q + PTR_W'(k)] == addr_i)) begin
        hit_o   = 1'b1;
        hit_idx = head_q + PTR_W'(k);
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i)      count_d = count_q + (PTR_W+1)'(1);
    else if (pop_i && !push_i) count_d = count_q - (PTR_W+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
    end else begin
      if (push_i) tail_q <= tail_q + PTR_W'(1);
      if (pop_i)  head_q <= head_q + PTR_W'(1);
      count_q <= count_d;
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) begin
      addr_q[tail_q] <= addr_i;
      data_q[tail_q] <= wdata_i;
    end
    if (coalesce_i) data_q[hit_idx] <= wdata_i;
  end

`ifdef WBUF_FWD_EN
  assign hit_data_o  = data_q[hit_idx];
`endif
  assign head_addr_o = addr_q[head_q];
  assign head_data_o = data_q[head_q];
  assign full_o      = (count_q == FULL_CNT);
  assign empty_o     = empty_q;

endmodule

// File: rtl/mem_write_buffer.sv
// Posted write buffer between cache_d and main memory; drains in FIFO order when idle.
// Define WBUF_FWD_EN to serve reads of buffered lines directly from the buffer.
module mem_write_buffer
  import mem_write_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = WBUF_DEPTH,
  parameter int unsigned ADDR_W = MEM_ADDR_WIDTH,
  parameter int unsigned DATA_W = MEM_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic [ADDR_W-1:0] up_addr,
  input  logic              up_read,
  output logic [DATA_W-1:0] up_rdata,
  input  logic              up_write,
  input  logic [DATA_W-1:0] up_wdata,
  output logic              up_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              wbuf_empty
);

  wb_state_e         state_q, state_d;
  logic              up_ready_q, up_ready_d;
  logic [DATA_W-1:0] up_rdata_q, up_rdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              push, pop, coalesce, drain;
  logic              hit, full, empty;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
`ifdef WBUF_FWD_EN
  logic [DATA_W-1:0] hit_data;
`endif

  mem_write_buffer_store #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_store (
    .clk         (clk),
    .rst_n       (proc_reset_n),
    .push_i      (push),
    .pop_i       (pop),
    .coalesce_i  (coalesce),
    .addr_i      (up_addr),
    .wdata_i     (up_wdata),
    .hit_o       (hit),
`ifdef WBUF_FWD_EN
    .hit_data_o  (hit_data),
`endif
    .head_addr_o (head_addr),
    .head_data_o (head_data),
    .full_o      (full),
    .empty_o     (empty)
  );

  always_comb begin
    state_d     = state_q;
    up_ready_d  = 1'b0;
    up_rdata_d  = up_rdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    push        = 1'b0;
    pop         = 1'b0;
    coalesce    = 1'b0;
    drain       = 1'b0;
    unique case (state_q)
      WB_IDLE: begin
        if (up_read) begin
`ifdef WBUF_FWD_EN
          if (hit) begin
            up_rdata_d = hit_data;
            up_ready_d = 1'b1;
            state_d    = WB_RESP;
          end else begin
            mem_read_d = 1'b1;
            mem_addr_d = up_addr;
            state_d    = WB_RD_MEM;
          end
`else
          // A read of a buffered line must not overtake its pending writeback.
          if (hit) begin
            drain = 1'b1;
          end else begin
            mem_read_d = 1'b1;
            mem_addr_d = up_addr;
            state_d    = WB_RD_MEM;
          end
`endif
        end else if (up_write) begin
          if (hit) begin
            coalesce   = 1'b1;
            up_ready_d = 1'b1;
            state_d    = WB_RESP;
          end else if (!full) begin
            push       = 1'b1;
            up_ready_d = 1'b1;
            state_d    = WB_RESP;
          end else begin
            drain = 1'b1;
          end
        end else if (!empty) begin
          drain = 1'b1;
        end
        if (drain) begin
          mem_write_d = 1'b1;
          mem_addr_d  = head_addr;
          mem_wdata_d = head_data;
          state_d     = WB_WR_MEM;
        end
      end
      WB_RD_MEM: begin
        if (mem_ready) begin
          up_rdata_d = mem_rdata;
          mem_read_d = 1'b0;
          up_ready_d = 1'b1;
          state_d    = WB_RESP;
        end
      end
      WB_WR_MEM: begin
        if (mem_ready) begin
          pop         = 1'b1;
          mem_write_d = 1'b0;
          state_d     = WB_IDLE;
        end
      end
      WB_RESP: state_d = WB_IDLE;
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q     <= WB_IDLE;
      up_ready_q  <= 1'b0;
      up_rdata_q  <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      up_ready_q  <= up_ready_d;
      up_rdata_q  <= up_rdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign up_ready   = up_ready_q;
  assign up_rdata   = up_rdata_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign wbuf_empty = empty;

endmodule
